gray_codec: RTL and testbench

GRAY_CODEC -- requirements
Module: gray_codec

---
 rtl/gray_codec_pkg.sv | 25 ++
 rtl/gray_prefix_xor.sv | 20 ++
 rtl/gray_codec.sv | 68 ++++++
 tb/tb_gray_codec.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_codec_pkg.sv
// Shared width constants and width-generic Gray conversion functions.
// Functions work on MAX_W-bit words; callers zero-extend inputs and truncate results.
package gray_codec_pkg;

  localparam int DEFAULT_N = 8;
  localparam int MAX_W     = 64;

  function automatic logic [MAX_W-1:0] bin_to_gray(input logic [MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits leave the running prefix at 0, so truncation is exact for any N <= MAX_W.
  function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] gray);
    logic [MAX_W-1:0] bin;
    logic             acc;
    bin = '0;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_prefix_xor.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_prefix_xor import gray_codec_pkg::*; #(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_codec.sv
// Registered Gray encoder and decoder with independent paths and a sticky round-trip self-check.
// N must lie in 1..MAX_W.
module gray_codec import gray_codec_pkg::*; #(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] bin_in,
  input  logic         bin_valid_in,
  output logic [N-1:0] gray_out,
  output logic         gray_valid_out,
  input  logic [N-1:0] gray_in,
  input  logic         gray_valid_in,
  output logic [N-1:0] bin_out,
  output logic         bin_valid_out,
  output logic         rt_err
);

  logic [N-1:0] dec_bin;
  logic [N-1:0] chk_bin;
  logic [N-1:0] src_q;

  gray_prefix_xor #(.N(N)) u_dec (
    .gray (gray_in),
    .bin  (dec_bin)
  );

  // Decodes the encoder's own registered output so it can be checked against its source word.
  gray_prefix_xor #(.N(N)) u_chk (
    .gray (gray_out),
    .bin  (chk_bin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_out       <= '0;
      gray_valid_out <= 1'b0;
      src_q          <= '0;
    end else begin
      gray_valid_out <= bin_valid_in;
      if (bin_valid_in) begin
        gray_out <= N'(bin_to_gray(MAX_W'(bin_in)));
        src_q    <= bin_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out       <= '0;
      bin_valid_out <= 1'b0;
    end else begin
      bin_valid_out <= gray_valid_in;
      if (gray_valid_in) begin
        bin_out <= dec_bin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_err <= 1'b0;
    end else if (gray_valid_out && (chk_bin != src_q)) begin
      rt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench for gray_codec: directed vectors, round trip, exhaustive sweep,
// randomized traffic against a table-based model, N=1/N=16 instances and async reset.
module tb_gray_codec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  bin_in = '0, gray_in = '0, gray_out, bin_out;
  logic        bin_valid_in = 1'b0, gray_valid_in = 1'b0;
  logic        gray_valid_out, bin_valid_out, rt_err;

  logic        bin_in1 = 1'b0, gray_in1 = 1'b0, gray_out1, bin_out1;
  logic        bv_in1 = 1'b0, gv_in1 = 1'b0, gv_out1, bv_out1, rt_err1;

  logic [15:0] bin_in16 = '0, gray_in16 = '0, gray_out16, bin_out16;
  logic        bv_in16 = 1'b0, gv_in16 = 1'b0, gv_out16, bv_out16, rt_err16;

  int vectors = 0;
  int miscompares = 0;

  int inv[256];
  bit seen[256];

  always #5 clk = ~clk;

  gray_codec #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .bin_in(bin_in), .bin_valid_in(bin_valid_in),
    .gray_out(gray_out), .gray_valid_out(gray_valid_out),
    .gray_in(gray_in), .gray_valid_in(gray_valid_in),
    .bin_out(bin_out), .bin_valid_out(bin_valid_out),
    .rt_err(rt_err)
  );

  gray_codec #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .bin_in(bin_in1), .bin_valid_in(bv_in1),
    .gray_out(gray_out1), .gray_valid_out(gv_out1),
    .gray_in(gray_in1), .gray_valid_in(gv_in1),
    .bin_out(bin_out1), .bin_valid_out(bv_out1),
    .rt_err(rt_err1)
  );

  gray_codec #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .bin_in(bin_in16), .bin_valid_in(bv_in16),
    .gray_out(gray_out16), .gray_valid_out(gv_out16),
    .gray_in(gray_in16), .gray_valid_in(gv_in16),
    .bin_out(bin_out16), .bin_valid_out(bv_out16),
    .rt_err(rt_err16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: binary bit i is the parity of all Gray bits at or above i.
  function automatic logic [15:0] ref_dec16(input logic [15:0] g);
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [7:0] enc_vec[5]  = '{8'h23, 8'hFF, 8'h00, 8'h10, 8'hAB};
  logic [7:0] enc_exp[5]  = '{8'h32, 8'h80, 8'h00, 8'h18, 8'hFE};
  logic [7:0] dec_vec[3]  = '{8'h32, 8'h80, 8'hFE};
  logic [7:0] dec_exp[3]  = '{8'h23, 8'hFF, 8'hAB};
  logic [7:0] rt_seq[16]  = '{8'h23, 8'h25, 8'hFF, 8'h13, 8'h00, 8'h11, 8'h99, 8'h11,
                              8'h22, 8'hFA, 8'hAF, 8'hBA, 8'hAB, 8'h91, 8'h01, 8'h10};

  initial begin
    logic [7:0]  exp_gray, exp_bin, rb, rg;
    logic        exp_gv, exp_bv;
    logic [15:0] r16;
    int          distinct;

    // Inverse table: the decoder must map each Gray code back to the value that produced it.
    for (int v = 0; v < 256; v++) inv[v ^ (v >> 1)] = v;

    #3;
    check("rst_gray_out", gray_out, 0);
    check("rst_bin_out", bin_out, 0);
    check("rst_gray_valid", gray_valid_out, 0);
    check("rst_bin_valid", bin_valid_out, 0);
    check("rst_rt_err", rt_err, 0);
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      bin_in = enc_vec[k]; bin_valid_in = 1'b1;
      tick();
      check("enc_gray", gray_out, enc_exp[k]);
      check("enc_valid", gray_valid_out, 1);
    end
    bin_valid_in = 1'b0;

    for (int k = 0; k < 3; k++) begin
      gray_in = dec_vec[k]; gray_valid_in = 1'b1;
      tick();
      check("dec_bin", bin_out, dec_exp[k]);
      check("dec_valid", bin_valid_out, 1);
    end
    gray_valid_in = 1'b0;

    bin_in = 8'h23; bin_valid_in = 1'b1;
    tick();
    check("hold_load", gray_out, 8'h32);
    for (int k = 0; k < 3; k++) begin
      bin_in = 8'($urandom); bin_valid_in = 1'b0;
      tick();
      check("hold_gray", gray_out, 8'h32);
      check("hold_valid", gray_valid_out, 0);
    end

    // Loop the encoder output straight back into the decoder.
    for (int k = 0; k <= 16; k++) begin
      bin_in = (k < 16) ? rt_seq[k] : 8'h00;
      bin_valid_in = (k < 16);
      gray_in = gray_out;
      gray_valid_in = gray_valid_out;
      tick();
      if (k >= 1) begin
        check("rt_bin", bin_out, rt_seq[k-1]);
        check("rt_valid", bin_valid_out, 1);
      end
    end
    bin_valid_in = 1'b0; gray_valid_in = 1'b0;
    tick();
    check("rt_err_after_loop", rt_err, 0);

    for (int v = 0; v < 256; v++) begin
      bin_in = 8'(v); gray_in = 8'(v);
      bin_valid_in = 1'b1; gray_valid_in = 1'b1;
      tick();
      check("sweep_enc", gray_out, 32'(v ^ (v >> 1)));
      check("sweep_dec", bin_out, 32'(inv[v]));
      seen[gray_out] = 1'b1;
    end
    distinct = 0;
    for (int v = 0; v < 256; v++) distinct += int'(seen[v]);
    check("sweep_bijective", distinct, 256);

    exp_gray = gray_out; exp_bin = bin_out; exp_gv = 1'b1; exp_bv = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rb = 8'($urandom); rg = 8'($urandom);
      bin_in = rb; gray_in = rg;
      bin_valid_in = 1'($urandom); gray_valid_in = 1'($urandom);
      if (bin_valid_in) exp_gray = rb ^ (rb >> 1);
      if (gray_valid_in) exp_bin = 8'(inv[rg]);
      exp_gv = bin_valid_in; exp_bv = gray_valid_in;
      tick();
      check("rnd_gray", gray_out, exp_gray);
      check("rnd_gv", gray_valid_out, exp_gv);
      check("rnd_bin", bin_out, exp_bin);
      check("rnd_bv", bin_valid_out, exp_bv);
    end
    check("rnd_rt_err", rt_err, 0);
    bin_valid_in = 1'b0; gray_valid_in = 1'b0;

    for (int v = 0; v < 2; v++) begin
      bin_in1 = 1'(v); gray_in1 = 1'(v); bv_in1 = 1'b1; gv_in1 = 1'b1;
      tick();
      check("n1_enc", gray_out1, v);
      check("n1_dec", bin_out1, v);
    end
    bv_in1 = 1'b0; gv_in1 = 1'b0;
    tick();
    check("n1_rt_err", rt_err1, 0);

    bin_in16 = 16'h8000; gray_in16 = 16'hC000; bv_in16 = 1'b1; gv_in16 = 1'b1;
    tick();
    check("n16_enc_msb", gray_out16, 16'hC000);
    check("n16_dec_msb", bin_out16, 16'h8000);
    for (int k = 0; k < 8; k++) begin
      r16 = 16'($urandom);
      bin_in16 = r16; gray_in16 = r16;
      tick();
      check("n16_enc", gray_out16, r16 ^ (r16 >> 1));
      check("n16_dec", bin_out16, ref_dec16(r16));
    end
    bv_in16 = 1'b0; gv_in16 = 1'b0;
    tick();
    check("n16_rt_err", rt_err16, 0);

    // Mid-stream async reset: outputs clear between edges, the in-flight word is dropped.
    bin_in = 8'hAB; gray_in = 8'hFE; bin_valid_in = 1'b1; gray_valid_in = 1'b1;
    tick();
    check("pre_rst_gray", gray_out, 8'hFE);
    bin_in = 8'h10; gray_in = 8'h18;
    #2 rst_n = 1'b0;
    #1;
    check("async_gray", gray_out, 0);
    check("async_bin", bin_out, 0);
    check("async_gv", gray_valid_out, 0);
    check("async_bv", bin_valid_out, 0);
    check("async_rt_err", rt_err, 0);
    tick();
    check("rst_drop_gv", gray_valid_out, 0);
    check("rst_drop_gray", gray_out, 0);
    bin_in = 8'h23; gray_in = 8'h80;
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_gray", gray_out, 8'h32);
    check("post_rst_gv", gray_valid_out, 1);
    check("post_rst_bin", bin_out, 8'hFF);
    check("post_rst_bv", bin_valid_out, 1);
    bin_valid_in = 1'b0; gray_valid_in = 1'b0;
    tick();
    check("final_rt_err", rt_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
